// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: widths, opcodes, ALU/mux encodings and the
// ID/EX control bundle used by the decode stage.
package rv32i_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      A_RS1  = 2'b00,
      A_PC   = 2'b01,
      A_ZERO = 2'b10
   } alu_a_sel_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        alu_src;
      result_src_t result_src;
      alu_a_sel_t  alu_a_sel;
      alu_ctrl_t   alu_ctrl;
      logic        illegal;
   } ctrl_t;

   // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
   function automatic alu_ctrl_t alu_op(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: IF/ID inputs, hazard and writeback controls, ID/EX outputs.
// slave = decode stage, master = the surrounding pipeline (or a bench).
interface decode_cycle_if;
   import rv32i_pkg::*;

   logic [XLEN-1:0]   instr_d;
   logic [XLEN-1:0]   pc_d;
   logic [XLEN-1:0]   pc_4_d;
   logic              stall_d;
   logic              flush_e;
   logic              reg_write_w;
   logic [REG_AW-1:0] rd_w;
   logic [XLEN-1:0]   result_w;

   logic [XLEN-1:0]   rd1_e, rd2_e, imm_e, pc_e, pc_4_e;
   logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
   logic              reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e;
   logic [1:0]        result_src_e;
   logic [1:0]        alu_a_sel_e;
   logic [3:0]        alu_ctrl_e;
   logic [2:0]        funct3_e;
   logic              illegal_e;

   modport slave (
      input  instr_d, pc_d, pc_4_d, stall_d, flush_e, reg_write_w, rd_w, result_w,
      output rd1_e, rd2_e, imm_e, pc_e, pc_4_e, rs1_e, rs2_e, rd_e,
             reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e,
             result_src_e, alu_a_sel_e, alu_ctrl_e, funct3_e, illegal_e
   );

   modport master (
      output instr_d, pc_d, pc_4_d, stall_d, flush_e, reg_write_w, rd_w, result_w,
      input  rd1_e, rd2_e, imm_e, pc_e, pc_4_e, rs1_e, rs2_e, rd_e,
             reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e,
             result_src_e, alu_a_sel_e, alu_ctrl_e, funct3_e, illegal_e
   );

endinterface

// File: rtl/register_file.sv
// 32x32 architectural register file, x0 hardwired to zero, combinational reads.
// DECODE_WB_BYPASS_EN: a same-cycle write to a read index is forwarded to the read.
module register_file
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [REG_AW-1:0] raddr1_i,
   input  logic [REG_AW-1:0] raddr2_i,
   output logic [XLEN-1:0]   rdata1_o,
   output logic [XLEN-1:0]   rdata2_o
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en;

   assign wr_en = we_i && (waddr_i != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   function automatic logic [XLEN-1:0] rd_port(input logic [REG_AW-1:0] addr);
      if (addr == '0)
         rd_port = '0;
`ifdef DECODE_WB_BYPASS_EN
      else if (wr_en && (waddr_i == addr))
         rd_port = wdata_i;
`endif
      else
         rd_port = regs_q[addr];
   endfunction

   assign rdata1_o = rd_port(raddr1_i);
   assign rdata2_o = rd_port(raddr2_i);

endmodule

// File: rtl/decode_cycle.sv
// RV32I instruction-decode stage: control decode, immediate generation, register
// read and the ID/EX pipeline register. Honours DECODE_WB_BYPASS_EN (register_file).
module decode_cycle
   import rv32i_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   decode_cycle_if.slave bus
);

   typedef struct packed {
      ctrl_t             ctrl;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc_4;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [2:0]        funct3;
   } idex_t;

   logic [XLEN-1:0] instr;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rd1, rd2;
   ctrl_t           ctrl_d;
   logic [XLEN-1:0] imm_d;
   idex_t           idex_d, idex_q;

   assign instr  = bus.instr_d;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   register_file u_rf (
      .clk      (clk),
      .rst      (rst),
      .we_i     (bus.reg_write_w),
      .waddr_i  (bus.rd_w),
      .wdata_i  (bus.result_w),
      .raddr1_i (instr[19:15]),
      .raddr2_i (instr[24:20]),
      .rdata1_o (rd1),
      .rdata2_o (rd2)
   );

   always_comb begin
      ctrl_d = '0;
      imm_d  = '0;
      case (opcode)
         OP_R: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = alu_op(funct3, instr[30]);
         end
         OP_IMM: begin
            // funct7[5] is part of the immediate except for the SRAI shift.
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_ctrl  = alu_op(funct3, (funct3 == 3'b101) && instr[30]);
            imm_d            = imm_i;
         end
         OP_LOAD: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.result_src = RES_MEM;
            imm_d             = imm_i;
         end
         OP_STORE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            imm_d            = imm_s;
         end
         OP_BRANCH: begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.alu_ctrl = ALU_SUB;
            imm_d           = imm_b;
         end
         OP_JAL: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.jump       = 1'b1;
            ctrl_d.result_src = RES_PC4;
            imm_d             = imm_j;
         end
         OP_JALR: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.jump       = 1'b1;
            ctrl_d.jalr       = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.result_src = RES_PC4;
            imm_d             = imm_i;
         end
         OP_LUI: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_a_sel = A_ZERO;
            imm_d            = imm_u;
         end
         OP_AUIPC: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_a_sel = A_PC;
            imm_d            = imm_u;
         end
         default: ctrl_d.illegal = 1'b1;
      endcase
   end

   always_comb begin
      idex_d        = '0;
      idex_d.ctrl   = ctrl_d;
      idex_d.rd1    = rd1;
      idex_d.rd2    = rd2;
      idex_d.imm    = imm_d;
      idex_d.pc     = bus.pc_d;
      idex_d.pc_4   = bus.pc_4_d;
      idex_d.rs1    = instr[19:15];
      idex_d.rs2    = instr[24:20];
      idex_d.rd     = instr[11:7];
      idex_d.funct3 = funct3;
   end

   // A bubble beats a stall so a squashed instruction cannot linger in EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               idex_q <= '0;
      else if (bus.flush_e)  idex_q <= '0;
      else if (!bus.stall_d) idex_q <= idex_d;
   end

   assign bus.rd1_e        = idex_q.rd1;
   assign bus.rd2_e        = idex_q.rd2;
   assign bus.imm_e        = idex_q.imm;
   assign bus.pc_e         = idex_q.pc;
   assign bus.pc_4_e       = idex_q.pc_4;
   assign bus.rs1_e        = idex_q.rs1;
   assign bus.rs2_e        = idex_q.rs2;
   assign bus.rd_e         = idex_q.rd;
   assign bus.reg_write_e  = idex_q.ctrl.reg_write;
   assign bus.mem_write_e  = idex_q.ctrl.mem_write;
   assign bus.branch_e     = idex_q.ctrl.branch;
   assign bus.jump_e       = idex_q.ctrl.jump;
   assign bus.jalr_e       = idex_q.ctrl.jalr;
   assign bus.alu_src_e    = idex_q.ctrl.alu_src;
   assign bus.result_src_e = idex_q.ctrl.result_src;
   assign bus.alu_a_sel_e  = idex_q.ctrl.alu_a_sel;
   assign bus.alu_ctrl_e   = idex_q.ctrl.alu_ctrl;
   assign bus.funct3_e     = idex_q.funct3;
   assign bus.illegal_e    = idex_q.ctrl.illegal;

endmodule
